// File: rtl/water_pkg.sv
// ============================================================================
// Module : water_pkg
// Brief  : Shared types and default constants for the drink reminder block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package water_pkg;

  typedef enum logic {WATCH, ALERT} reminder_state_t;

  localparam int DEF_INTERVAL = 1800;
  localparam int DEF_GOAL     = 2;

endpackage

`default_nettype wire

// File: rtl/drink_reminder_if.sv
// ============================================================================
// Module : drink_reminder_if
// Brief  : Tick/intake/ack inputs and alert/status outputs of drink_reminder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface drink_reminder_if #(
  parameter int WIDTH = 6,
  parameter int TW    = 11
);

  logic             tick;
  logic [WIDTH-1:0] water_drunk;
  logic             ack;
  logic             alert;
  logic [WIDTH-1:0] drunk_window;
  logic [TW-1:0]    time_left;

  modport master (
    output tick, water_drunk, ack,
    input  alert, drunk_window, time_left
  );

  modport slave (
    input  tick, water_drunk, ack,
    output alert, drunk_window, time_left
  );

endinterface

`default_nettype wire

// File: rtl/drink_reminder_interval_timer.sv
// ============================================================================
// Module : interval_timer
// Brief  : Reloadable down-counter; stops at 1 and flags window end on en.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interval_timer #(
  parameter int INTERVAL = 1800,
  parameter int TW       = $clog2(INTERVAL + 1)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          load,
  input  wire logic          en,
  input  wire logic          hold,
  output logic      [TW-1:0] count,
  output logic               done
);

  localparam logic [TW-1:0] C_RELOAD = TW'(INTERVAL);
  localparam logic [TW-1:0] C_ONE    = TW'(1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= C_RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

  // Load wins over everything so a tick on the reload cycle is swallowed.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = C_RELOAD;
    end else if (!hold && en && (count_q > C_ONE)) begin
      count_d = count_q - C_ONE;
    end
  end

  assign count = count_q;
  assign done  = en && (count_q == C_ONE);

endmodule

`default_nettype wire

// File: rtl/drink_reminder.sv
// ============================================================================
// Module : drink_reminder
// Brief  : Per-window intake check with registered reminder alert.
//          Optional REMINDER_BLINK_EN: alert toggles on each tick in ALERT.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drink_reminder
  import water_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int GOAL     = DEF_GOAL,
  parameter int TW       = $clog2(INTERVAL + 1)
) (
  input wire logic         clk,
  input wire logic         reset,
  drink_reminder_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_GOAL = WIDTH'(GOAL);

  reminder_state_t  state_q, state_d;
  logic             alert_q, alert_d;
  logic [WIDTH-1:0] baseline_q, baseline_d;
  logic [WIDTH-1:0] delta;
  logic             goal_met;
  logic             timer_load;
  logic             timer_hold;
  logic             timer_done;
  logic [TW-1:0]    timer_count;

  // Modular subtraction absorbs a single upstream counter wrap per window.
  assign delta    = bus.water_drunk - baseline_q;
  assign goal_met = (delta >= C_GOAL);

  interval_timer #(
    .INTERVAL (INTERVAL),
    .TW       (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (bus.tick),
    .hold  (timer_hold),
    .count (timer_count),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WATCH;
      alert_q    <= 1'b0;
      baseline_q <= '0;
    end else begin
      state_q    <= state_d;
      alert_q    <= alert_d;
      baseline_q <= baseline_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alert_d    = alert_q;
    baseline_d = baseline_q;
    timer_load = 1'b0;
    timer_hold = 1'b0;
    unique case (state_q)
      WATCH: begin
        if (timer_done) begin
          if (goal_met) begin
            timer_load = 1'b1;
            baseline_d = bus.water_drunk;
          end else begin
            state_d = ALERT;
            alert_d = 1'b1;
          end
        end
      end
      ALERT: begin
        timer_hold = 1'b1;
        if (bus.ack || goal_met) begin
          state_d    = WATCH;
          alert_d    = 1'b0;
          timer_load = 1'b1;
          baseline_d = bus.water_drunk;
        end else begin
`ifdef REMINDER_BLINK_EN
          if (bus.tick) begin
            alert_d = ~alert_q;
          end
`else
          alert_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = WATCH;
        alert_d = 1'b0;
      end
    endcase
  end

  assign bus.alert        = alert_q;
  assign bus.drunk_window = delta;
  assign bus.time_left    = timer_count;

endmodule

`default_nettype wire

// File: tb/tb_drink_reminder.sv
// ============================================================================
// Module : tb_drink_reminder
// Brief  : Directed self-checking bench, INTERVAL=4, GOAL=2, WIDTH=6.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drink_reminder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  drink_reminder_if #(.WIDTH(6), .TW(3)) bus ();

  drink_reminder #(
    .WIDTH    (6),
    .INTERVAL (4),
    .GOAL     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle(input logic t, input logic [5:0] wd, input logic a);
    @(negedge clk);
    bus.tick        = t;
    bus.water_drunk = wd;
    bus.ack         = a;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.ack  = 1'b0;
  endtask

  task automatic do_reset();
    bus.tick        = 1'b0;
    bus.ack         = 1'b0;
    bus.water_drunk = 6'd0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.tick        = 1'b0;
    bus.ack         = 1'b0;
    bus.water_drunk = 6'd0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL reset_alert got %b want 0", bus.alert); end
    checks++; if (bus.time_left !== 3'd4) begin errors++; $display("FAIL reset_time_left got %0d want 4", bus.time_left); end
    checks++; if (bus.drunk_window !== 6'd0) begin errors++; $display("FAIL reset_drunk_window got %0d want 0", bus.drunk_window); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_goal_met();
    cycle(1'b1, 6'd0, 1'b0);
    checks++; if (bus.time_left !== 3'd3) begin errors++; $display("FAIL gm_dec got %0d want 3", bus.time_left); end
    cycle(1'b1, 6'd3, 1'b0);
    checks++; if (bus.drunk_window !== 6'd3) begin errors++; $display("FAIL gm_window got %0d want 3", bus.drunk_window); end
    cycle(1'b1, 6'd3, 1'b0);
    cycle(1'b1, 6'd3, 1'b0);
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL gm_alert got %b want 0", bus.alert); end
    checks++; if (bus.time_left !== 3'd4) begin errors++; $display("FAIL gm_reload got %0d want 4", bus.time_left); end
    checks++; if (bus.drunk_window !== 6'd0) begin errors++; $display("FAIL gm_rebase got %0d want 0", bus.drunk_window); end
  endtask

  task automatic test_alert_entry();
    do_reset();
    repeat (3) cycle(1'b1, 6'd1, 1'b0);
    checks++; if (bus.alert !== 1'b0 || bus.time_left !== 3'd1) begin errors++; $display("FAIL al_pre got alert=%b tl=%0d want alert=0 tl=1", bus.alert, bus.time_left); end
    cycle(1'b1, 6'd1, 1'b0);
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL al_entry got %b want 1", bus.alert); end
    checks++; if (bus.time_left !== 3'd1) begin errors++; $display("FAIL al_time_left got %0d want 1", bus.time_left); end
    checks++; if (bus.drunk_window !== 6'd1) begin errors++; $display("FAIL al_window got %0d want 1", bus.drunk_window); end
    cycle(1'b1, 6'd1, 1'b0);
`ifdef REMINDER_BLINK_EN
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL al_blink1 got %b want 0", bus.alert); end
`else
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL al_steady1 got %b want 1", bus.alert); end
`endif
    checks++; if (bus.time_left !== 3'd1) begin errors++; $display("FAIL al_frozen got %0d want 1", bus.time_left); end
    cycle(1'b1, 6'd1, 1'b0);
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL al_tick2 got %b want 1", bus.alert); end
    cycle(1'b0, 6'd1, 1'b0);
    checks++; if (bus.alert !== 1'b1 || bus.time_left !== 3'd1) begin errors++; $display("FAIL al_idle got alert=%b tl=%0d want alert=1 tl=1", bus.alert, bus.time_left); end
  endtask

  task automatic test_ack();
    cycle(1'b0, 6'd1, 1'b1);
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL ack_alert got %b want 0", bus.alert); end
    checks++; if (bus.time_left !== 3'd4) begin errors++; $display("FAIL ack_reload got %0d want 4", bus.time_left); end
    checks++; if (bus.drunk_window !== 6'd0) begin errors++; $display("FAIL ack_rebase got %0d want 0", bus.drunk_window); end
    cycle(1'b1, 6'd1, 1'b1);
    checks++; if (bus.alert !== 1'b0 || bus.time_left !== 3'd3) begin errors++; $display("FAIL ack_watch got alert=%b tl=%0d want alert=0 tl=3", bus.alert, bus.time_left); end
  endtask

  task automatic test_catch_up();
    do_reset();
    repeat (4) cycle(1'b1, 6'd1, 1'b0);
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL cu_entry got %b want 1", bus.alert); end
    cycle(1'b0, 6'd3, 1'b0);
    checks++; if (bus.alert !== 1'b0 || bus.time_left !== 3'd4 || bus.drunk_window !== 6'd0) begin
      errors++; $display("FAIL cu_exit got alert=%b tl=%0d dw=%0d want alert=0 tl=4 dw=0", bus.alert, bus.time_left, bus.drunk_window); end
    repeat (4) cycle(1'b1, 6'd4, 1'b0);
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL cu_reentry got %b want 1", bus.alert); end
    // ack, enough intake and a tick together: one exit, tick absorbed by reload
    cycle(1'b1, 6'd5, 1'b1);
    checks++; if (bus.alert !== 1'b0 || bus.time_left !== 3'd4 || bus.drunk_window !== 6'd0) begin
      errors++; $display("FAIL cu_combo got alert=%b tl=%0d dw=%0d want alert=0 tl=4 dw=0", bus.alert, bus.time_left, bus.drunk_window); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (4) cycle(1'b1, 6'd62, 1'b0);
    checks++; if (bus.alert !== 1'b0 || bus.drunk_window !== 6'd0 || bus.time_left !== 3'd4) begin
      errors++; $display("FAIL wr_base got alert=%b dw=%0d tl=%0d want 0 0 4", bus.alert, bus.drunk_window, bus.time_left); end
    cycle(1'b1, 6'd63, 1'b0);
    cycle(1'b1, 6'd1, 1'b0);
    checks++; if (bus.drunk_window !== 6'd3) begin errors++; $display("FAIL wr_window got %0d want 3", bus.drunk_window); end
    cycle(1'b1, 6'd1, 1'b0);
    cycle(1'b1, 6'd1, 1'b0);
    checks++; if (bus.alert !== 1'b0 || bus.time_left !== 3'd4) begin errors++; $display("FAIL wr_end got alert=%b tl=%0d want 0 4", bus.alert, bus.time_left); end
  endtask

  task automatic test_reset_in_alert();
    do_reset();
    repeat (4) cycle(1'b1, 6'd0, 1'b0);
    checks++; if (bus.alert !== 1'b1) begin errors++; $display("FAIL ra_entry got %b want 1", bus.alert); end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.alert !== 1'b0) begin errors++; $display("FAIL ra_async_alert got %b want 0", bus.alert); end
    checks++; if (bus.time_left !== 3'd4) begin errors++; $display("FAIL ra_async_tl got %0d want 4", bus.time_left); end
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 6'd0, 1'b0);
    checks++; if (bus.time_left !== 3'd3 || bus.alert !== 1'b0) begin errors++; $display("FAIL ra_restart got alert=%b tl=%0d want 0 3", bus.alert, bus.time_left); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.tick        = 1'b0;
    bus.ack         = 1'b0;
    bus.water_drunk = 6'd0;
    test_reset();
    test_goal_met();
    test_alert_entry();
    test_ack();
    test_catch_up();
    test_wrap();
    test_reset_in_alert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/drink_reminder.md
Name: drink_reminder

Overview:
- Downstream consumer of the cumulative water-drunk counter.
- Splits time into fixed windows of INTERVAL ticks and checks the intake per window against GOAL.
- Raises a registered alert when a window closes short of GOAL.
- Alert clears on user acknowledge, or once intake catches up; drives the reminder LED/buzzer.

Parameters:
- WIDTH, 6: width of the incoming water_drunk count and of drunk_window.
- INTERVAL, 1800: window length in tick strobes; must be >= 2.
- GOAL, 2: minimum units drunk per window; must be < 2**WIDTH. GOAL=0 means alert never fires.
- TW, $clog2(INTERVAL+1): timer width (derived; do not override).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous active-high reset.
- tick, input, 1: one-cycle time-base strobe (e.g. 1 Hz enable).
- water_drunk, input, WIDTH: running total from the upstream accumulator; wraps modulo 2**WIDTH.
- ack, input, 1: synchronised, one-cycle user acknowledge pulse.
- alert, output, 1: reminder indicator.
- drunk_window, output, WIDTH: units drunk since the current window started.
- time_left, output, TW: ticks remaining in the current window.

Behaviour:
- Reset is asynchronous, active-high, on clock clk. During reset:
  - state=WATCH, alert=0, timer=INTERVAL, baseline=0.
  - drunk_window=0 and time_left=INTERVAL.
- delta = water_drunk - baseline, modulo 2**WIDTH.
  - drunk_window = delta, combinational.
  - A single counter wrap inside a window is handled correctly.
  - More than 2**WIDTH-1 units in one window aliases. This is a documented limitation.
- WATCH state:
  - On each tick: if timer > 1, timer decrements.
  - If timer == 1 at the tick (window end):
    - delta >= GOAL: stay in WATCH, timer <= INTERVAL, baseline <= water_drunk.
    - delta < GOAL: go to ALERT, with alert=1 from that same clock edge. Timer is held.
  - ack is ignored in WATCH.
- ALERT state:
  - Timer is frozen; ticks do not decrement it.
  - Exit on ack=1 OR delta >= GOAL. On exit: state <= WATCH, alert <= 0, timer <= INTERVAL, baseline <= water_drunk, all on the same edge.
  - ack and sufficient delta arriving on the same cycle count as a single exit.
- Simultaneous events:
  - A tick on the exit cycle is consumed by the reload; it does not also decrement the timer.
  - When a tick and a water_drunk change arrive on the same window-end cycle, the current water_drunk value is used.
- time_left = timer.
- All outputs are registered, except the combinational drunk_window.
- Latency: alert rises on the clock edge that samples the window-end tick, and falls on the edge that samples the exit condition.
- Reset mid-ALERT drops alert immediately (asynchronous) and restarts a full window.

Optional Feature:
- Macro: REMINDER_BLINK_EN.
- Defined:
  - While in ALERT, alert toggles on every tick. It starts at 1 on ALERT entry.
  - On exit it is forced to 0.
- Undefined: alert is steady 1 for the whole time in ALERT.
- State transitions are identical in both builds.

Decomposition:
- Package water_pkg holds:
  - typedef enum logic {WATCH, ALERT} reminder_state_t.
  - Default constants DEF_INTERVAL=1800 and DEF_GOAL=2.
- One sub-module, interval_timer:
  - Parameterised down-counter of width TW.
  - Inputs: load, en (tick), hold.
  - Outputs: count and done (count==1 && en).
  - drink_reminder instantiates it and owns the FSM and baseline register.

Test Plan:
All scenarios use INTERVAL=4, GOAL=2, WIDTH=6.
- Reset release, 4 ticks, water_drunk raised 0->3 mid-window -> alert stays 0, time_left reloads to 4, drunk_window reads 0 after the window end.
- water_drunk held at 1, 4 ticks -> alert=1 on the 4th tick edge, time_left frozen at 1 under further ticks, drunk_window=1.
- In ALERT, pulse ack -> alert=0 next edge, time_left=4, baseline=1 so drunk_window=0.
- In ALERT, raise water_drunk 1->3 with no ack -> alert clears on that edge, new window starts.
- Wrap: baseline=62, water_drunk goes 62->1 within a window -> drunk_window=3, no alert at window end.
- Assert reset during ALERT mid-cycle -> alert=0 immediately, without a clock edge. With REMINDER_BLINK_EN, alert toggles 1,0,1 across 3 ticks in ALERT.
